// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED blink sequencer: FSM states and blink rate select codes.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Rate select codes as {switch_1, switch_2}
  localparam logic [1:0] RATE_00 = 2'b00;
  localparam logic [1:0] RATE_01 = 2'b01;
  localparam logic [1:0] RATE_10 = 2'b10;
  localparam logic [1:0] RATE_11 = 2'b11;

endpackage

// File: rtl/led_blink_sequencer_tick_prescaler.sv
// Free-running 0..DIV-1 counter that pulses o_tick on its last count; held at 0 while cleared.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = !i_clear && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || o_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_sequencer.sv
// Walks a small (rate select, duration) table and drives one led_blink instance step by step.
//
//   state | meaning
//   IDLE  | waiting for i_start, outputs low
//   LOAD  | read table[step]; zero duration skips straight to the next step
//   RUN   | hold rate select for dur ticks
//   DONE  | one-cycle o_done pulse, outputs low
module led_blink_sequencer
  import led_ctrl_pkg::*;
#(
  parameter  int CLK_HZ    = 25_000_000,
  parameter  int TICK_HZ   = 1000,
  parameter  int NUM_STEPS = 4,
  parameter  int DUR_W     = 16,
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [STEP_W-1:0] i_wr_addr,
  input  logic [1:0]        i_wr_sel,
  input  logic [DUR_W-1:0]  i_wr_dur,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic              o_enable,
  output logic              o_switch_1,
  output logic              o_switch_2,
  output logic              o_busy,
  output logic              o_done,
  output logic [STEP_W-1:0] o_step
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic              ran_q, ran_d;
  logic              enable_q, enable_d;
  logic [1:0]        sw_q, sw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        tbl_sel_q [NUM_STEPS];
  logic [1:0]        tbl_sel_d [NUM_STEPS];
  logic [DUR_W-1:0]  tbl_dur_q [NUM_STEPS];
  logic [DUR_W-1:0]  tbl_dur_d [NUM_STEPS];

  logic              tick;
  logic              wr_ok;
  logic              last_step;
  logic              advance;
  logic [1:0]        cur_sel;
  logic [DUR_W-1:0]  cur_dur;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (state_q != ST_RUN),
    .o_tick  (tick)
  );

  assign wr_ok     = i_wr_en && (int'(i_wr_addr) < NUM_STEPS);
  assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));
  assign cur_sel   = tbl_sel_q[step_q];
  assign cur_dur   = tbl_dur_q[step_q];

  always_comb begin
    tbl_sel_d = tbl_sel_q;
    tbl_dur_d = tbl_dur_q;
    if (wr_ok) begin
      tbl_sel_d[i_wr_addr] = i_wr_sel;
      tbl_dur_d[i_wr_addr] = i_wr_dur;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    ran_d    = ran_q;
    enable_d = enable_q;
    sw_d     = sw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    advance  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          state_d = ST_LOAD;
          step_d  = '0;
          ran_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (cur_dur != '0) begin
          state_d  = ST_RUN;
          enable_d = 1'b1;
          sw_d     = cur_sel;
          cnt_d    = cur_dur;
          ran_d    = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (cnt_q == DUR_W'(1)) begin
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs stay at the old step's value through the following LOAD so the LED never drops out.
    if (advance) begin
      if (!last_step) begin
        step_d  = step_q + 1'b1;
        state_d = ST_LOAD;
      end else if (i_loop && ran_q) begin
        step_d  = '0;
        ran_d   = 1'b0;
        state_d = ST_LOAD;
      end else begin
        state_d  = ST_DONE;
        done_d   = 1'b1;
        enable_d = 1'b0;
        sw_d     = RATE_00;
        busy_d   = 1'b0;
      end
    end

    if (i_stop) begin
      state_d  = ST_IDLE;
      enable_d = 1'b0;
      sw_d     = RATE_00;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      ran_q    <= 1'b0;
      enable_q <= 1'b0;
      sw_q     <= RATE_00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_sel_q[i] <= RATE_00;
        tbl_dur_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      ran_q     <= ran_d;
      enable_q  <= enable_d;
      sw_q      <= sw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tbl_sel_q <= tbl_sel_d;
      tbl_dur_q <= tbl_dur_d;
    end
  end

  assign o_enable   = enable_q;
  assign o_switch_1 = sw_q[1];
  assign o_switch_2 = sw_q[0];
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_step     = step_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer: 4-step build plus a 3-step build for address range checks.
module tb_led_blink_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en, start, stop, loop_en;
  logic [1:0]  wr_addr, wr_sel;
  logic [15:0] wr_dur;
  logic        en, s1, s2, busy, done;
  logic [1:0]  step;

  logic        w3_en, start3, stop3, loop3;
  logic [1:0]  w3_addr, w3_sel;
  logic [15:0] w3_dur;
  logic        en3, s13, s23, busy3, done3;
  logic [1:0]  step3;

  int tests = 0;
  int fails = 0;

  led_blink_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_STEPS(4), .DUR_W(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_sel(wr_sel),
    .i_wr_dur(wr_dur), .i_start(start), .i_stop(stop), .i_loop(loop_en),
    .o_enable(en), .o_switch_1(s1), .o_switch_2(s2), .o_busy(busy), .o_done(done), .o_step(step)
  );

  led_blink_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_STEPS(3), .DUR_W(16)) dut3 (
    .i_clock(clk), .i_reset(rst), .i_wr_en(w3_en), .i_wr_addr(w3_addr), .i_wr_sel(w3_sel),
    .i_wr_dur(w3_dur), .i_start(start3), .i_stop(stop3), .i_loop(loop3),
    .o_enable(en3), .o_switch_1(s13), .o_switch_2(s23), .o_busy(busy3), .o_done(done3), .o_step(step3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] s, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_sel = s; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs n cycles on the 4-step DUT, tallying enabled cycles per rate, busy cycles, done pulses and 11->00 wraps.
  task automatic monitor(input int n, output int c00, output int c01, output int c10, output int c11,
                         output int nbusy, output int ndone, output int nwrap);
    logic [1:0] prev_sw;
    logic       prev_en;
    c00 = 0; c01 = 0; c10 = 0; c11 = 0; nbusy = 0; ndone = 0; nwrap = 0;
    prev_sw = {s1, s2}; prev_en = en;
    for (int i = 0; i < n; i++) begin
      tick();
      if (en) begin
        case ({s1, s2})
          2'b00: c00++;
          2'b01: c01++;
          2'b10: c10++;
          default: c11++;
        endcase
        if (prev_en && prev_sw == 2'b11 && {s1, s2} == 2'b00) nwrap++;
      end
      if (busy) nbusy++;
      if (done) ndone++;
      prev_sw = {s1, s2}; prev_en = en;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests++;
    if ({en, s1, s2, busy, done, step} !== 7'd0) begin
      $display("FAIL reset_outputs: got %b expected 0000000", {en, s1, s2, busy, done, step});
      fails++;
    end
    tests++;
    if ({en3, s13, s23, busy3, done3, step3} !== 7'd0) begin
      $display("FAIL reset_outputs3: got %b expected 0000000", {en3, s13, s23, busy3, done3, step3});
      fails++;
    end
  endtask

  task automatic test_single_pass();
    int c00, c01, c10, c11, nb, nd, nw;
    wr(2'd0, 2'b00, 16'd2);
    wr(2'd1, 2'b01, 16'd3);
    wr(2'd2, 2'b10, 16'd0);
    wr(2'd3, 2'b11, 16'd1);
    loop_en = 1'b0;
    pulse_start();
    tests++;
    if ({busy, en} !== 2'b10) begin
      $display("FAIL pass_load_cycle: got busy,en=%b expected 10", {busy, en});
      fails++;
    end
    monitor(70, c00, c01, c10, c11, nb, nd, nw);
    tests++;
    if (c00 !== 21) begin $display("FAIL pass_sw00_cycles: got %0d expected 21", c00); fails++; end
    tests++;
    if (c01 !== 32) begin $display("FAIL pass_sw01_cycles: got %0d expected 32", c01); fails++; end
    tests++;
    if (c10 !== 0) begin $display("FAIL pass_sw10_cycles: got %0d expected 0", c10); fails++; end
    tests++;
    if (c11 !== 10) begin $display("FAIL pass_sw11_cycles: got %0d expected 10", c11); fails++; end
    tests++;
    if (nb !== 63) begin $display("FAIL pass_busy_cycles: got %0d expected 63", nb); fails++; end
    tests++;
    if (nd !== 1) begin $display("FAIL pass_done_pulses: got %0d expected 1", nd); fails++; end
    tests++;
    if ({en, s1, s2, busy, done} !== 5'd0 || step !== 2'd3) begin
      $display("FAIL pass_final_state: got outs=%b step=%0d expected 00000 step=3",
               {en, s1, s2, busy, done}, step);
      fails++;
    end
  endtask

  task automatic test_loop_stop();
    int c00, c01, c10, c11, nb, nd, nw;
    loop_en = 1'b1;
    pulse_start();
    monitor(79, c00, c01, c10, c11, nb, nd, nw);
    loop_en = 1'b0;
    tests++;
    if (nd !== 0) begin $display("FAIL loop_no_done: got %0d expected 0", nd); fails++; end
    tests++;
    if (nw !== 1) begin $display("FAIL loop_wrap_count: got %0d expected 1", nw); fails++; end
    tests++;
    if (nb !== 79) begin $display("FAIL loop_busy_cycles: got %0d expected 79", nb); fails++; end
    tests++;
    if ({en, s1, s2, step} !== 5'b10000) begin
      $display("FAIL loop_second_pass_step0: got %b expected 10000", {en, s1, s2, step});
      fails++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tests++;
    if ({en, busy, done} !== 3'b000) begin
      $display("FAIL stop_outputs: got en,busy,done=%b expected 000", {en, busy, done});
      fails++;
    end
    monitor(5, c00, c01, c10, c11, nb, nd, nw);
    tests++;
    if (nd !== 0 || nb !== 0) begin
      $display("FAIL stop_stays_idle: got done=%0d busy=%0d expected 0 0", nd, nb);
      fails++;
    end
  endtask

  task automatic test_all_zero();
    int c00, c01, c10, c11, nb, nd, nw;
    for (int i = 0; i < 4; i++) wr(2'(i), 2'b11, 16'd0);
    loop_en = 1'b1;
    pulse_start();
    monitor(10, c00, c01, c10, c11, nb, nd, nw);
    loop_en = 1'b0;
    tests++;
    if (nb !== 3) begin $display("FAIL zero_load_cycles: got %0d expected 3", nb); fails++; end
    tests++;
    if (nd !== 1) begin $display("FAIL zero_done_pulses: got %0d expected 1", nd); fails++; end
    tests++;
    if (c00 + c01 + c10 + c11 !== 0) begin
      $display("FAIL zero_enable_cycles: got %0d expected 0", c00 + c01 + c10 + c11);
      fails++;
    end
  endtask

  task automatic test_start_stop_and_write();
    int c00, c01, c11, nd, nb;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    tests++;
    if ({busy, en, done} !== 3'b000) begin
      $display("FAIL start_stop_same_cycle: got busy,en,done=%b expected 000", {busy, en, done});
      fails++;
    end
    wr(2'd0, 2'b00, 16'd2);
    wr(2'd1, 2'b01, 16'd1);
    wr(2'd2, 2'b10, 16'd0);
    wr(2'd3, 2'b11, 16'd1);
    pulse_start();
    c00 = 0; c01 = 0; c11 = 0; nd = 0; nb = 1;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      if (cyc == 5) begin
        start = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd1; wr_sel = 2'b01; wr_dur = 16'd5;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (en && {s1, s2} == 2'b00) c00++;
      if (en && {s1, s2} == 2'b01) c01++;
      if (en && {s1, s2} == 2'b11) c11++;
      if (busy) nb++;
      if (done) nd++;
    end
    tests++;
    if (c00 !== 21) begin $display("FAIL busy_start_ignored_sw00: got %0d expected 21", c00); fails++; end
    tests++;
    if (c01 !== 52) begin $display("FAIL midrun_write_sw01: got %0d expected 52", c01); fails++; end
    tests++;
    if (c11 !== 10) begin $display("FAIL midrun_write_sw11: got %0d expected 10", c11); fails++; end
    tests++;
    if (nb !== 84 || nd !== 1) begin
      $display("FAIL midrun_write_totals: got busy=%0d done=%0d expected 84 1", nb, nd);
      fails++;
    end
  endtask

  task automatic test_reset_mid_run();
    int c00, c01, c10, c11, nb, nd, nw;
    pulse_start();
    monitor(10, c00, c01, c10, c11, nb, nd, nw);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({en, s1, s2, busy, done, step} !== 7'd0) begin
      $display("FAIL reset_mid_run: got %b expected 0000000", {en, s1, s2, busy, done, step});
      fails++;
    end
    pulse_start();
    monitor(10, c00, c01, c10, c11, nb, nd, nw);
    tests++;
    if (nb !== 3 || nd !== 1 || c00 + c01 + c10 + c11 !== 0) begin
      $display("FAIL reset_clears_table: got busy=%0d done=%0d en=%0d expected 3 1 0",
               nb, nd, c00 + c01 + c10 + c11);
      fails++;
    end
  endtask

  task automatic test_addr_range();
    int nb, nd, ne;
    w3_en = 1'b1; w3_addr = 2'd3; w3_sel = 2'b11; w3_dur = 16'd5;
    tick();
    w3_en = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    nb = busy3 ? 1 : 0; nd = 0; ne = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy3) nb++;
      if (done3) nd++;
      if (en3) ne++;
    end
    tests++;
    if (nb !== 3 || nd !== 1 || ne !== 0) begin
      $display("FAIL oob_write_ignored: got busy=%0d done=%0d en=%0d expected 3 1 0", nb, nd, ne);
      fails++;
    end
    w3_en = 1'b1; w3_addr = 2'd2; w3_sel = 2'b11; w3_dur = 16'd1;
    tick();
    w3_en = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    nb = busy3 ? 1 : 0; nd = 0; ne = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy3) nb++;
      if (done3) nd++;
      if (en3 && {s13, s23} == 2'b11) ne++;
    end
    tests++;
    if (nb !== 13 || nd !== 1 || ne !== 10) begin
      $display("FAIL last_step_of_3: got busy=%0d done=%0d en11=%0d expected 13 1 10", nb, nd, ne);
      fails++;
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_sel = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    w3_en = 1'b0; w3_addr = '0; w3_sel = '0; w3_dur = '0;
    start3 = 1'b0; stop3 = 1'b0; loop3 = 1'b0;
    test_reset();
    test_single_pass();
    test_loop_stop();
    test_all_zero();
    test_start_stop_and_write();
    test_reset_mid_run();
    test_addr_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
